// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: finds the first {rot4, imm8} with value == imm8 ROR (2*rot4).
// Define IMM_ROT_ENCODER_INVERT_EN to add a second pass over ~value.
module imm_rot_encoder #(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_value,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        found,
  output logic [7:0]  imm8,
  output logic [3:0]  rot4,
  output logic        inverted
);

  localparam int         CPC  = CHECKS_PER_CYCLE;
  localparam logic [4:0] STEP = 5'(CPC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_cand, w_cand_n;
  logic [4:0]  r_rot_cnt, w_rot_cnt_n;
  logic        r_found, w_found_n;
  logic [7:0]  r_imm8, w_imm8_n;
  logic [3:0]  r_rot4, w_rot4_n;
`ifdef IMM_ROT_ENCODER_INVERT_EN
  logic [31:0] r_orig, w_orig_n;
  logic        r_pass, w_pass_n;
  logic        r_inv, w_inv_n;
`endif

  logic [31:0] w_rv [CPC];
  logic        w_hit;
  logic [7:0]  w_hit_imm;
  logic [3:0]  w_hit_rot;
  logic        w_last;

  function automatic logic [31:0] rol2(
    input logic [31:0] v,
    input logic [4:0]  r
  );
    logic [63:0] t;
    t = {v, v} << {r, 1'b0};
    return t[63:32];
  endfunction

  always_comb begin
    for (int k = 0; k < CPC; k++) begin
      w_rv[k] = rol2(r_cand, r_rot_cnt + 5'(k));
    end
  end

  // Walk from the top so the lowest rotation wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_imm = '0;
    w_hit_rot = '0;
    for (int k = CPC - 1; k >= 0; k--) begin
      if (w_rv[k][31:8] == 24'd0) begin
        w_hit     = 1'b1;
        w_hit_imm = w_rv[k][7:0];
        w_hit_rot = 4'(r_rot_cnt + 5'(k));
      end
    end
  end

  assign w_last = (r_rot_cnt + STEP) == 5'd16;

  always_comb begin
    w_state_n   = r_state;
    w_cand_n    = r_cand;
    w_rot_cnt_n = r_rot_cnt;
    w_found_n   = r_found;
    w_imm8_n    = r_imm8;
    w_rot4_n    = r_rot4;
`ifdef IMM_ROT_ENCODER_INVERT_EN
    w_orig_n    = r_orig;
    w_pass_n    = r_pass;
    w_inv_n     = r_inv;
`endif
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_cand_n    = req_value;
          w_rot_cnt_n = '0;
`ifdef IMM_ROT_ENCODER_INVERT_EN
          w_orig_n    = req_value;
          w_pass_n    = 1'b0;
`endif
          w_state_n   = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (w_hit) begin
          w_found_n = 1'b1;
          w_imm8_n  = w_hit_imm;
          w_rot4_n  = w_hit_rot;
`ifdef IMM_ROT_ENCODER_INVERT_EN
          w_inv_n   = r_pass;
`endif
          w_state_n = S_DONE;
        end else if (w_last) begin
          w_found_n = 1'b0;
          w_imm8_n  = '0;
          w_rot4_n  = '0;
          w_state_n = S_DONE;
`ifdef IMM_ROT_ENCODER_INVERT_EN
          w_inv_n   = 1'b0;
          if (!r_pass) begin
            w_cand_n    = ~r_orig;
            w_pass_n    = 1'b1;
            w_rot_cnt_n = '0;
            w_state_n   = S_SEARCH;
          end
`endif
        end else begin
          w_rot_cnt_n = r_rot_cnt + STEP;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cand    <= '0;
      r_rot_cnt <= '0;
      r_found   <= 1'b0;
      r_imm8    <= '0;
      r_rot4    <= '0;
`ifdef IMM_ROT_ENCODER_INVERT_EN
      r_orig    <= '0;
      r_pass    <= 1'b0;
      r_inv     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_cand    <= w_cand_n;
      r_rot_cnt <= w_rot_cnt_n;
      r_found   <= w_found_n;
      r_imm8    <= w_imm8_n;
      r_rot4    <= w_rot4_n;
`ifdef IMM_ROT_ENCODER_INVERT_EN
      r_orig    <= w_orig_n;
      r_pass    <= w_pass_n;
      r_inv     <= w_inv_n;
`endif
    end
  end

  assign found = r_found;
  assign imm8  = r_imm8;
  assign rot4  = r_rot4;
`ifdef IMM_ROT_ENCODER_INVERT_EN
  assign inverted = r_inv;
`else
  assign inverted = 1'b0;
`endif

endmodule

// File: tb/tb_imm_rot_encoder.sv
// tb_imm_rot_encoder: directed vectors on two instances (1 and 4 checks/cycle).
// Expected values follow IMM_ROT_ENCODER_INVERT_EN when it is defined.
module tb_imm_rot_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rv  [2];
  logic        rr  [2];
  logic        pv  [2];
  logic        pr  [2];
  logic        fnd [2];
  logic        inv [2];
  logic [31:0] val [2];
  logic [7:0]  imm [2];
  logic [3:0]  rot [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_rot_encoder #(.CHECKS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv[0]), .req_ready(rr[0]), .req_value(val[0]),
    .resp_valid(pv[0]), .resp_ready(pr[0]),
    .found(fnd[0]), .imm8(imm[0]), .rot4(rot[0]), .inverted(inv[0])
  );

  imm_rot_encoder #(.CHECKS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(rv[1]), .req_ready(rr[1]), .req_value(val[1]),
    .resp_valid(pv[1]), .resp_ready(pr[1]),
    .found(fnd[1]), .imm8(imm[1]), .rot4(rot[1]), .inverted(inv[1])
  );

  typedef struct {
    logic [31:0] v;
    logic        f;
    logic [7:0]  i;
    logic [3:0]  r;
    logic        n;
    int          l1;
    int          l4;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_req(input int d, input vec_t t);
    int    lat;
    string tag;
    tag = $sformatf("cpc%0d_%08h", (d != 0) ? 4 : 1, t.v);
    chk({tag, "_ready"}, 32'(rr[d]), 32'd1);
    rv[d]  = 1'b1;
    val[d] = t.v;
    @(posedge clk); #1;
    rv[d]  = 1'b0;
    val[d] = '0;
    lat = 1;
    while (!pv[d] && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'((d != 0) ? t.l4 : t.l1));
    chk({tag, "_found"}, 32'(fnd[d]), 32'(t.f));
    chk({tag, "_imm8"}, 32'(imm[d]), 32'(t.i));
    chk({tag, "_rot4"}, 32'(rot[d]), 32'(t.r));
    chk({tag, "_inv"}, 32'(inv[d]), 32'(t.n));
    pr[d] = 1'b1;
    @(posedge clk); #1;
    pr[d] = 1'b0;
    chk({tag, "_idle_rdy"}, 32'(rr[d]), 32'd1);
    chk({tag, "_idle_vld"}, 32'(pv[d]), 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'h000000FF, 1'b1, 8'hFF, 4'd0,  1'b0, 2,  2};
    tbl[1] = '{32'hFF000000, 1'b1, 8'hFF, 4'd4,  1'b0, 6,  3};
    tbl[2] = '{32'hF000000F, 1'b1, 8'hFF, 4'd2,  1'b0, 4,  2};
    tbl[3] = '{32'h00000000, 1'b1, 8'h00, 4'd0,  1'b0, 2,  2};
    tbl[4] = '{32'h000003FC, 1'b1, 8'hFF, 4'd15, 1'b0, 17, 5};
    tbl[5] = '{32'h00AB0000, 1'b1, 8'hAB, 4'd8,  1'b0, 10, 4};
    tbl[6] = '{32'h80000001, 1'b1, 8'h06, 4'd1,  1'b0, 3,  2};
    tbl[7] = '{32'h00000104, 1'b1, 8'h41, 4'd15, 1'b0, 17, 5};
`ifdef IMM_ROT_ENCODER_INVERT_EN
    tbl[8] = '{32'h00000102, 1'b0, 8'h00, 4'd0,  1'b0, 33, 9};
    tbl[9] = '{32'hFFFFFF00, 1'b1, 8'hFF, 4'd0,  1'b1, 18, 6};
`else
    tbl[8] = '{32'h00000102, 1'b0, 8'h00, 4'd0,  1'b0, 17, 5};
    tbl[9] = '{32'hFFFFFF00, 1'b0, 8'h00, 4'd0,  1'b0, 17, 5};
`endif

    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; pr[d] = 1'b0; val[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_ready", d), 32'(rr[d]), 32'd1);
      chk($sformatf("rst%0d_vld", d), 32'(pv[d]), 32'd0);
      chk($sformatf("rst%0d_found", d), 32'(fnd[d]), 32'd0);
      chk($sformatf("rst%0d_imm8", d), 32'(imm[d]), 32'd0);
      chk($sformatf("rst%0d_rot4", d), 32'(rot[d]), 32'd0);
      chk($sformatf("rst%0d_inv", d), 32'(inv[d]), 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++)
        run_req(d, tbl[i]);

    // Back-pressure: result must hold and a stray request must be dropped.
    for (int d = 0; d < 2; d++) begin
      int w;
      rv[d]  = 1'b1;
      val[d] = 32'hFF000000;
      @(posedge clk); #1;
      rv[d]  = 1'b0;
      w = 0;
      while (!pv[d] && w < 60) begin
        @(posedge clk); #1;
        w++;
      end
      for (int c = 0; c < 10; c++) begin
        if (c == 3) begin
          rv[d]  = 1'b1;
          val[d] = 32'h000000FF;
        end
        @(posedge clk); #1;
        rv[d] = 1'b0;
        chk($sformatf("hold%0d_c%0d_vld", d, c), 32'(pv[d]), 32'd1);
        chk($sformatf("hold%0d_c%0d_rdy", d, c), 32'(rr[d]), 32'd0);
        chk($sformatf("hold%0d_c%0d_imm", d, c), 32'(imm[d]), 32'hFF);
        chk($sformatf("hold%0d_c%0d_rot", d, c), 32'(rot[d]), 32'd4);
      end
      pr[d] = 1'b1;
      @(posedge clk); #1;
      pr[d] = 1'b0;
      chk($sformatf("hold%0d_rel_rdy", d), 32'(rr[d]), 32'd1);
      chk($sformatf("hold%0d_rel_vld", d), 32'(pv[d]), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("hold%0d_noq_vld", d), 32'(pv[d]), 32'd0);
      chk($sformatf("hold%0d_noq_rdy", d), 32'(rr[d]), 32'd1);
    end

    // Asynchronous reset in the middle of a search.
    for (int d = 0; d < 2; d++) begin
      rv[d]  = 1'b1;
      val[d] = 32'h00000102;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) rv[d] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst%0d_rdy", d), 32'(rr[d]), 32'd1);
      chk($sformatf("arst%0d_vld", d), 32'(pv[d]), 32'd0);
      chk($sformatf("arst%0d_found", d), 32'(fnd[d]), 32'd0);
      chk($sformatf("arst%0d_imm8", d), 32'(imm[d]), 32'd0);
      chk($sformatf("arst%0d_rot4", d), 32'(rot[d]), 32'd0);
    end
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) run_req(d, tbl[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
